// File: rtl/tx_pkt_wr_arbiter_if.sv
// Requester-side beat handshake and TX FIFO write-port bundle of the packet write arbiter.
// The slave modport is the arbiter's view; master is the host/FIFO side.
interface tx_pkt_wr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 64,
   parameter int USEDW_W = 13
);
   logic                      tx_en;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_sop;
   logic [NUM_REQ-1:0]        req_eop;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_we;
   logic                      tx_full;
   logic [USEDW_W-1:0]        tx_usedw;
   logic [NUM_REQ-1:0]        grant;
   logic                      busy;
   logic                      pkt_err;
   logic [2:0]                err_req;

   modport master (
      output tx_en, req_valid, req_sop, req_eop, req_data, tx_full, tx_usedw,
      input  req_ready, tx_data, tx_we, grant, busy, pkt_err, err_req
   );

   modport slave (
      input  tx_en, req_valid, req_sop, req_eop, req_data, tx_full, tx_usedw,
      output req_ready, tx_data, tx_we, grant, busy, pkt_err, err_req
   );
endinterface

// File: rtl/tx_pkt_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing the LMAC TX packet-data FIFO write port,
// gating every beat on FIFO occupancy and truncating packets longer than MAX_BEATS.
module tx_pkt_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 64,
   parameter int USEDW_W    = 13,
   parameter int FIFO_DEPTH = 32,
   parameter int START_FREE = 4,
   parameter int MAX_BEATS  = 1200
) (
   input logic                clk,
   input logic                rst,
   tx_pkt_wr_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

   localparam logic [10:0] MAX_CNT  = 11'(MAX_BEATS);
   localparam logic [2:0]  LAST_IDX = 3'(NUM_REQ - 1);

   state_t              state_q, state_d;
   logic [2:0]          rr_ptr_q, rr_ptr_d;
   logic [2:0]          gnt_idx_q, gnt_idx_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [10:0]         beat_cnt_q, beat_cnt_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic                tx_we_q, tx_we_d;
   logic                pkt_err_q, pkt_err_d;
   logic [2:0]          err_req_q, err_req_d;

   logic [USEDW_W:0]    used_sum;
   logic                space_ok, start_ok;
   logic [NUM_REQ-1:0]  cand, pick_oh, ready_vec;
   logic                lo_found, hi_found;
   logic [2:0]          lo_idx, hi_idx, pick_idx, next_ptr;
   logic [DATA_W-1:0]   own_data;
   logic                own_eop, accept;

   // Occupancy includes the write we are issuing this cycle, which tx_usedw does not yet see.
   assign used_sum = {1'b0, bus.tx_usedw} + {{USEDW_W{1'b0}}, tx_we_q};
   assign space_ok = !bus.tx_full && (int'(used_sum) < FIFO_DEPTH);
   assign start_ok = bus.tx_en && (int'(used_sum) + START_FREE <= FIFO_DEPTH);

   assign cand     = bus.req_valid & bus.req_sop;
   assign next_ptr = (gnt_idx_q == LAST_IDX) ? 3'd0 : gnt_idx_q + 3'd1;

   // First sop candidate at or after rr_ptr, wrapping to the lowest candidate otherwise.
   always_comb begin
      lo_found = 1'b0;
      hi_found = 1'b0;
      lo_idx   = '0;
      hi_idx   = '0;
      pick_oh  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            lo_found = 1'b1;
            lo_idx   = 3'(i);
         end
         if (cand[i] && (i >= int'(rr_ptr_q))) begin
            hi_found = 1'b1;
            hi_idx   = 3'(i);
         end
      end
      pick_idx = hi_found ? hi_idx : lo_idx;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == 3'(i)) pick_oh[i] = 1'b1;
      end
   end

   always_comb begin
      own_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) own_data = bus.req_data[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      ready_vec = '0;
      unique case (state_q)
         XFER:    ready_vec = space_ok ? grant_q : '0;
         DRAIN:   ready_vec = grant_q;
         default: ready_vec = '0;
      endcase
   end

   assign own_eop = |(bus.req_eop & grant_q);
   assign accept  = |(ready_vec & bus.req_valid);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_idx_d  = gnt_idx_q;
      grant_d    = grant_q;
      beat_cnt_d = beat_cnt_q;
      tx_data_d  = tx_data_q;
      tx_we_d    = 1'b0;
      pkt_err_d  = 1'b0;
      err_req_d  = err_req_q;
      unique case (state_q)
         IDLE: begin
            if (start_ok && lo_found) begin
               state_d    = XFER;
               gnt_idx_d  = pick_idx;
               grant_d    = pick_oh;
               beat_cnt_d = '0;
            end
         end
         XFER: begin
            if (accept) begin
               tx_we_d    = 1'b1;
               tx_data_d  = own_data;
               beat_cnt_d = beat_cnt_q + 11'd1;
               if (own_eop) begin
                  state_d  = IDLE;
                  grant_d  = '0;
                  rr_ptr_d = next_ptr;
               end else if (beat_cnt_q + 11'd1 == MAX_CNT) begin
                  // The limit beat is still written; the rest of the packet is swallowed.
                  state_d   = DRAIN;
                  pkt_err_d = 1'b1;
                  err_req_d = gnt_idx_q;
               end
            end
         end
         DRAIN: begin
            if (accept && own_eop) begin
               state_d  = IDLE;
               grant_d  = '0;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         gnt_idx_q  <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
         tx_data_q  <= '0;
         tx_we_q    <= 1'b0;
         pkt_err_q  <= 1'b0;
         err_req_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_idx_q  <= gnt_idx_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
         tx_data_q  <= tx_data_d;
         tx_we_q    <= tx_we_d;
         pkt_err_q  <= pkt_err_d;
         err_req_q  <= err_req_d;
      end
   end

   assign bus.req_ready = ready_vec;
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_we     = tx_we_q;
   assign bus.grant     = grant_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.pkt_err   = pkt_err_q;
   assign bus.err_req   = err_req_q;
endmodule
